// File: rtl/morty_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble generation, long-latency
// register scoreboard, and a redirect FSM that kills an in-flight fetch.
//
// state   | meaning
// IDLE    | no outstanding fetch to discard
// KILL    | redirect seen with a fetch in flight; drop it when if_ack_i arrives
module morty_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int REG_AW    = 5,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_long_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [1:0]        redirect_i,
  input  logic              if_ack_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic              if_kill_o,
  output logic [1:0]        pc_sel_o,
  output logic              busy_o
);

  localparam int NREG = 2 ** REG_AW;

  typedef enum logic {ST_IDLE = 1'b0, ST_KILL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   pend_q, pend_d, byp_mask, pend_eff;
  logic [STAGES-1:0] req_eff, stall_c, bubble_c;
  logic              hz, accept, set_en, acc;

  // A write completing this cycle hides its pending bit when bypass is enabled
  always_comb begin
    byp_mask = '0;
    if (BYPASS_WB && wb_valid_i) byp_mask[wb_rd_i] = 1'b1;
    pend_eff = pend_q & ~byp_mask;
    hz = id_valid_i & ((id_rs1_used_i & pend_eff[id_rs1_i]) |
                       (id_rs2_used_i & pend_eff[id_rs2_i]) |
                       (id_long_i     & pend_eff[id_rd_i]));
  end

  // WB can never stall, so its request is masked before the suffix-OR
  always_comb begin
    req_eff             = stall_req_i;
    req_eff[STAGES-1]   = 1'b0;
    stall_c             = '0;
    acc                 = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc        = acc | req_eff[i];
      stall_c[i] = acc;
    end
    stall_c[1] = stall_c[1] | hz;
    stall_c[0] = stall_c[0] | stall_c[1];
  end

  assign accept = (redirect_i != 2'b00) & ~stall_c[2];

  always_comb begin
    bubble_c = '0;
    for (int i = 1; i < STAGES; i++) begin
      bubble_c[i] = stall_c[i-1] & ~stall_c[i];
    end
    if (accept) begin
      bubble_c[1] = 1'b1;
      bubble_c[2] = 1'b1;
      if (redirect_i == 2'b11) bubble_c[3] = 1'b1;
    end
    if (state_q == ST_KILL) bubble_c[1] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && stall_req_i[0] && !if_ack_i) state_d = ST_KILL;
      ST_KILL: if (!accept && if_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit pending
  assign set_en = id_valid_i & id_long_i & (id_rd_i != '0) & ~stall_c[1] & ~accept;

  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) pend_d[wb_rd_i] = 1'b0;
    if (set_en)     pend_d[id_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    stall_o   = '0;
    bubble_o  = '1;
    if_kill_o = 1'b0;
    pc_sel_o  = 2'b00;
    busy_o    = 1'b0;
    if (rst_n_i) begin
      stall_o   = stall_c;
      bubble_o  = bubble_c;
      if_kill_o = accept | (state_q == ST_KILL);
      pc_sel_o  = accept ? redirect_i : 2'b00;
      busy_o    = |pend_q;
    end
  end

endmodule

// File: tb/tb_morty_hazard_ctrl.sv
// Bench for morty_hazard_ctrl: directed vector table, hand sequences for the
// redirect cases, then random traffic against a rule-level reference model.
module tb_morty_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] stall_req;
  logic       id_valid, rs1_used, rs2_used, id_long, wb_valid, if_ack;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic [1:0] redirect;
  logic [4:0] stall, bubble;
  logic       if_kill, busy;
  logic [1:0] pc_sel;

  always #5 clk = ~clk;

  morty_hazard_ctrl #(.STAGES(5), .REG_AW(5), .BYPASS_WB(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_req_i(stall_req),
    .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_i(rd), .id_long_i(id_long), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .redirect_i(redirect), .if_ack_i(if_ack),
    .stall_o(stall), .bubble_o(bubble), .if_kill_o(if_kill),
    .pc_sel_o(pc_sel), .busy_o(busy)
  );

  typedef struct packed {
    logic       rst_n;
    logic [4:0] sreq;
    logic       idv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       lng;
    logic       wbv;
    logic [4:0] wbrd;
    logic [1:0] redir;
    logic       ack;
    logic [4:0] e_stall;
    logic [4:0] e_bubble;
    logic       e_kill;
    logic [1:0] e_pc;
    logic       e_busy;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t v(
    input logic rst_n_v, input logic [4:0] sreq, input logic idv,
    input logic [4:0] rs1_v, input logic u1, input logic [4:0] rs2_v, input logic u2,
    input logic [4:0] rd_v, input logic lng, input logic wbv, input logic [4:0] wbrd,
    input logic [1:0] redir, input logic ack,
    input logic [4:0] es, input logic [4:0] eb, input logic ek,
    input logic [1:0] ep, input logic ebusy);
    vec_t t;
    t.rst_n = rst_n_v; t.sreq = sreq; t.idv = idv; t.rs1 = rs1_v; t.u1 = u1;
    t.rs2 = rs2_v; t.u2 = u2; t.rd = rd_v; t.lng = lng; t.wbv = wbv; t.wbrd = wbrd;
    t.redir = redir; t.ack = ack; t.e_stall = es; t.e_bubble = eb; t.e_kill = ek;
    t.e_pc = ep; t.e_busy = ebusy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst_n; stall_req = t.sreq; id_valid = t.idv; rs1 = t.rs1;
    rs1_used = t.u1; rs2 = t.rs2; rs2_used = t.u2; rd = t.rd; id_long = t.lng;
    wb_valid = t.wbv; wb_rd = t.wbrd; redirect = t.redir; if_ack = t.ack;
  endtask

  task automatic check_vec(input vec_t t, input string tag);
    chk({tag, ".stall"},  8'(stall),   8'(t.e_stall));
    chk({tag, ".bubble"}, 8'(bubble),  8'(t.e_bubble));
    chk({tag, ".kill"},   8'(if_kill), 8'(t.e_kill));
    chk({tag, ".pc_sel"}, 8'(pc_sel),  8'(t.e_pc));
    chk({tag, ".busy"},   8'(busy),    8'(t.e_busy));
  endtask

  task automatic step(input vec_t t, input string tag);
    @(posedge clk);
    #1 drive(t);
    #3 check_vec(t, tag);
  endtask

  // Reference model state: set of pending registers and "fetch being killed"
  bit pend_m [32];
  bit kill_m;
  bit m_s1, m_acc;

  function automatic bit pe(input logic [4:0] r, input vec_t t);
    return pend_m[r] && !(t.wbv && t.wbrd == r);
  endfunction

  task automatic model_eval(inout vec_t t);
    bit s [5];
    bit hz, acc, any;
    hz = t.idv && ((t.u1 && pe(t.rs1, t)) || (t.u2 && pe(t.rs2, t)) ||
                   (t.lng && pe(t.rd, t)));
    for (int i = 0; i < 5; i++) begin
      s[i] = 1'b0;
      for (int j = i; j < 4; j++) if (t.sreq[j]) s[i] = 1'b1;
    end
    s[1] = s[1] || hz;
    s[0] = s[0] || s[1];
    acc = (t.redir != 2'b00) && !s[2];
    any = 1'b0;
    for (int r = 0; r < 32; r++) any = any || pend_m[r];
    for (int i = 0; i < 5; i++) t.e_stall[i] = s[i];
    t.e_bubble[0] = 1'b0;
    for (int i = 1; i < 5; i++) t.e_bubble[i] = s[i-1] && !s[i];
    if (acc || kill_m) t.e_bubble[1] = 1'b1;
    if (acc) t.e_bubble[2] = 1'b1;
    if (acc && t.redir == 2'b11) t.e_bubble[3] = 1'b1;
    t.e_kill = acc || kill_m;
    t.e_pc   = acc ? t.redir : 2'b00;
    t.e_busy = any;
    if (!t.rst_n) begin
      t.e_stall = '0; t.e_bubble = 5'b11111; t.e_kill = 1'b0; t.e_pc = 2'b00; t.e_busy = 1'b0;
    end
    m_s1  = s[1];
    m_acc = acc;
  endtask

  task automatic model_update(input vec_t t);
    if (!t.rst_n) begin
      for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
      kill_m = 1'b0;
    end else begin
      if (t.wbv) pend_m[t.wbrd] = 1'b0;
      if (t.idv && t.lng && t.rd != 0 && !m_s1 && !m_acc) pend_m[t.rd] = 1'b1;
      if (kill_m) begin
        if (!m_acc && t.ack) kill_m = 1'b0;
      end else if (m_acc && t.sreq[0] && !t.ack) begin
        kill_m = 1'b1;
      end
    end
  endtask

  vec_t tbl [$];

  initial begin
    vec_t t;
    rst_n = 1'b0; stall_req = '0; id_valid = 1'b0; rs1 = '0; rs2 = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rd = '0; id_long = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; redirect = '0; if_ack = 1'b0;
    kill_m = 1'b0;

    //              rst sreq     idv rs1 u1 rs2 u2 rd lng wbv wbrd rdr ack | stall    bubble   k pc busy
    tbl.push_back(v(0, 5'b11111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b11111, 0, 2'd0, 0));
    tbl.push_back(v(0, 5'b11111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b11111, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00011, 5'b00100, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00011, 5'b00100, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 1, 5, 1, 0, 0, 0, 0, 1, 5, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 7, 1, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 7, 1, 0, 0, 2'd0, 0, 5'b00011, 5'b00100, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 7, 1, 0, 0, 2'd0, 0, 5'b00011, 5'b00100, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 1, 0, 0, 0, 0, 7, 1, 1, 7, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 7, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 1));
    tbl.push_back(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b01111, 5'b10000, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00001, 5'b00010, 0, 2'd0, 0));
    tbl.push_back(v(1, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Taken branch with a fetch in flight: kill until the response arrives
    step(v(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 5'b00001, 5'b00110, 1, 2'd1, 0), "kill_a");
    step(v(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00001, 5'b00010, 1, 2'd0, 0), "kill_b");
    step(v(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00001, 5'b00010, 1, 2'd0, 0), "kill_c");
    step(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 5'b00000, 5'b00010, 1, 2'd0, 0), "kill_ack");
    step(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0), "kill_idle");

    // Exception held while EX is stalled, accepted once the stall drops
    step(v(1, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 5'b01111, 5'b10000, 0, 2'd0, 0), "exc_hold");
    step(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 5'b00000, 5'b01110, 1, 2'd3, 0), "exc_take");
    step(v(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 5'b00000, 0, 2'd0, 0), "exc_after");

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      t = '0;
      t.rst_n = !((i == 0) || ($urandom_range(0, 49) == 0));
      for (int b = 0; b < 5; b++) t.sreq[b] = ($urandom_range(0, 4) == 0);
      t.idv   = ($urandom_range(0, 3) != 0);
      t.rs1   = 5'($urandom_range(0, 7));
      t.rs2   = 5'($urandom_range(0, 7));
      t.u1    = 1'($urandom_range(0, 1));
      t.u2    = 1'($urandom_range(0, 1));
      t.rd    = 5'($urandom_range(0, 7));
      t.lng   = ($urandom_range(0, 2) == 0);
      t.wbv   = ($urandom_range(0, 2) == 0);
      t.wbrd  = 5'($urandom_range(0, 7));
      t.redir = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      t.ack   = 1'($urandom_range(0, 1));
      model_eval(t);
      drive(t);
      #3 check_vec(t, $sformatf("rnd%0d", i));
      model_update(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
